// File: rtl/vga_mode_pkg.sv
// rtl/vga_mode_pkg.sv - shared FSM states and mode-field width defaults for the VGA sync generator
// Contents:
//   vga_state_e      - IDLE / RUN state encoding
//   VGA_*_DEFAULT    - default bits-per-colour and axis counter/mode widths
package vga_mode_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vga_state_e;

  localparam int VGA_BPC_DEFAULT = 4;
  localparam int VGA_HW_DEFAULT  = 12;
  localparam int VGA_VW_DEFAULT  = 12;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping position counter plus region compares
// Ports:
//   i_clk, i_rst_n      - clock, asynchronous active-low reset
//   i_clr               - force count to 0 (wins over i_inc)
//   i_inc               - advance count, wrapping from i_raw-1 to 0
//   i_active            - first position outside the active region
//   i_porch, i_synch    - sync region is i_porch <= count < i_synch
//   i_raw               - axis length
//   o_last              - count is at i_raw-1
//   o_active, o_sync    - count lies in the active / sync region
module vga_axis_counter #(
  parameter int W = 12
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_active,
  input  logic [W-1:0] i_porch,
  input  logic [W-1:0] i_synch,
  input  logic [W-1:0] i_raw,
  output logic         o_last,
  output logic         o_active,
  output logic         o_sync
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Wrapping on raw-1 keeps the count bounded, so no wider arithmetic is needed.
  assign o_last   = (count_q == (i_raw - ONE));
  assign o_active = (count_q < i_active);
  assign o_sync   = (count_q >= i_porch) && (count_q < i_synch);

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_inc) begin
      count_d = o_last ? '0 : (count_q + ONE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA/HDMI raster timing generator with pixel request and aligned output
// Ports:
//   i_pixclk, i_reset_n          - pixel clock, asynchronous active-low reset
//   i_en                         - run request, sampled in IDLE and at frame boundaries
//   i_hm_* / i_vm_*              - width/height, sync start, sync end, total for each axis
//   i_pixel                      - pixel from the pattern source, one cycle after o_rd
//   o_rd, o_newline, o_newframe  - stage-1 pixel request and line/frame start strobes
//   o_hsync, o_vsync, o_de       - stage-2 sync outputs and data enable
//   o_pixel                      - i_pixel gated by o_de
module vga_sync_gen
  import vga_mode_pkg::*;
#(
  parameter int   BPC       = VGA_BPC_DEFAULT,
  parameter int   HW        = VGA_HW_DEFAULT,
  parameter int   VW        = VGA_VW_DEFAULT,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic             i_pixclk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic [HW-1:0]    i_hm_width,
  input  logic [HW-1:0]    i_hm_porch,
  input  logic [HW-1:0]    i_hm_synch,
  input  logic [HW-1:0]    i_hm_raw,
  input  logic [VW-1:0]    i_vm_height,
  input  logic [VW-1:0]    i_vm_porch,
  input  logic [VW-1:0]    i_vm_synch,
  input  logic [VW-1:0]    i_vm_raw,
  input  logic [3*BPC-1:0] i_pixel,
  output logic             o_rd,
  output logic             o_newline,
  output logic             o_newframe,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic [3*BPC-1:0] o_pixel
);

  vga_state_e state_d, state_q;

  logic [HW-1:0] h_width_d, h_width_q, h_porch_d, h_porch_q;
  logic [HW-1:0] h_synch_d, h_synch_q, h_raw_d, h_raw_q;
  logic [VW-1:0] v_height_d, v_height_q, v_porch_d, v_porch_q;
  logic [VW-1:0] v_synch_d, v_synch_q, v_raw_d, v_raw_q;

  logic rd_d, rd_q, newline_d, newline_q, newframe_d, newframe_q;
  logic hs1_d, hs1_q, vs1_d, vs1_q;
  logic de_d, de_q, hs2_d, hs2_q, vs2_d, vs2_q;

  logic run, h_mode_ok, v_mode_ok, start_ok, frame_end, reload;
  logic h_last, h_act, h_sync, v_last, v_act, v_sync;

  assign run = (state_q == ST_RUN);

  assign h_mode_ok = (i_hm_width != '0) && (i_hm_width < i_hm_porch) &&
                     (i_hm_porch < i_hm_synch) && (i_hm_synch < i_hm_raw);
  assign v_mode_ok = (i_vm_height != '0) && (i_vm_height < i_vm_porch) &&
                     (i_vm_porch < i_vm_synch) && (i_vm_synch < i_vm_raw);
  assign start_ok  = i_en && h_mode_ok && v_mode_ok;
  assign frame_end = h_last && v_last;

  // Counters are held at zero in IDLE so RUN always begins at the raster origin.
  vga_axis_counter #(.W(HW)) u_hcnt (
    .i_clk    (i_pixclk),
    .i_rst_n  (i_reset_n),
    .i_clr    (!run),
    .i_inc    (run),
    .i_active (h_width_q),
    .i_porch  (h_porch_q),
    .i_synch  (h_synch_q),
    .i_raw    (h_raw_q),
    .o_last   (h_last),
    .o_active (h_act),
    .o_sync   (h_sync)
  );

  vga_axis_counter #(.W(VW)) u_vcnt (
    .i_clk    (i_pixclk),
    .i_rst_n  (i_reset_n),
    .i_clr    (!run),
    .i_inc    (run && h_last),
    .i_active (v_height_q),
    .i_porch  (v_porch_q),
    .i_synch  (v_synch_q),
    .i_raw    (v_raw_q),
    .o_last   (v_last),
    .o_active (v_act),
    .o_sync   (v_sync)
  );

  always_comb begin
    state_d    = state_q;
    reload     = 1'b0;
    h_width_d  = h_width_q;
    h_porch_d  = h_porch_q;
    h_synch_d  = h_synch_q;
    h_raw_d    = h_raw_q;
    v_height_d = v_height_q;
    v_porch_d  = v_porch_q;
    v_synch_d  = v_synch_q;
    v_raw_d    = v_raw_q;

    // Mode inputs are only looked at on entry and at frame boundaries, so
    // mid-frame changes cannot tear the raster.
    if (!run) begin
      if (start_ok) begin
        state_d = ST_RUN;
        reload  = 1'b1;
      end
    end else if (frame_end) begin
      reload = 1'b1;
      if (!start_ok) begin
        state_d = ST_IDLE;
      end
    end

    if (reload) begin
      h_width_d  = i_hm_width;
      h_porch_d  = i_hm_porch;
      h_synch_d  = i_hm_synch;
      h_raw_d    = i_hm_raw;
      v_height_d = i_vm_height;
      v_porch_d  = i_vm_porch;
      v_synch_d  = i_vm_synch;
      v_raw_d    = i_vm_raw;
    end

    // Stage 1: straight from the counters. Line/frame strobes are dropped
    // when the boundary sends us to IDLE, since no new line will follow.
    rd_d       = run && h_act && v_act;
    hs1_d      = run && h_sync;
    vs1_d      = run && v_sync;
    newline_d  = (!run && start_ok) || (run && h_last && (!frame_end || start_ok));
    newframe_d = (!run && start_ok) || (run && frame_end && start_ok);

    // Stage 2: lines up with the pixel returned by the source.
    de_d  = rd_q;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
  end

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      h_width_q  <= '0;
      h_porch_q  <= '0;
      h_synch_q  <= '0;
      h_raw_q    <= '0;
      v_height_q <= '0;
      v_porch_q  <= '0;
      v_synch_q  <= '0;
      v_raw_q    <= '0;
      rd_q       <= 1'b0;
      newline_q  <= 1'b0;
      newframe_q <= 1'b0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      de_q       <= 1'b0;
      hs2_q      <= 1'b0;
      vs2_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_width_q  <= h_width_d;
      h_porch_q  <= h_porch_d;
      h_synch_q  <= h_synch_d;
      h_raw_q    <= h_raw_d;
      v_height_q <= v_height_d;
      v_porch_q  <= v_porch_d;
      v_synch_q  <= v_synch_d;
      v_raw_q    <= v_raw_d;
      rd_q       <= rd_d;
      newline_q  <= newline_d;
      newframe_q <= newframe_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      de_q       <= de_d;
      hs2_q      <= hs2_d;
      vs2_q      <= vs2_d;
    end
  end

  // Sync flops hold "active"; polarity is applied after them so reset gives
  // the inactive level without a clock edge.
  assign o_rd       = rd_q;
  assign o_newline  = newline_q;
  assign o_newframe = newframe_q;
  assign o_de       = de_q;
  assign o_hsync    = hs2_q ? HSYNC_POL : ~HSYNC_POL;
  assign o_vsync    = vs2_q ? VSYNC_POL : ~VSYNC_POL;
  assign o_pixel    = de_q ? i_pixel : '0;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen against a raster-position model
module tb_vga_sync_gen;

  localparam int   BPC = 4;
  localparam int   HW  = 12;
  localparam int   VW  = 12;
  localparam logic HP  = 1'b0;
  localparam logic VP  = 1'b0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_en;
  logic [HW-1:0]    i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw;
  logic [VW-1:0]    i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw;
  logic [3*BPC-1:0] i_pixel;
  logic             o_rd, o_newline, o_newframe, o_hsync, o_vsync, o_de;
  logic [3*BPC-1:0] o_pixel;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .BPC(BPC), .HW(HW), .VW(VW), .HSYNC_POL(HP), .VSYNC_POL(VP)
  ) dut (
    .i_pixclk    (clk),
    .i_reset_n   (rst_n),
    .i_en        (i_en),
    .i_hm_width  (i_hm_width),
    .i_hm_porch  (i_hm_porch),
    .i_hm_synch  (i_hm_synch),
    .i_hm_raw    (i_hm_raw),
    .i_vm_height (i_vm_height),
    .i_vm_porch  (i_vm_porch),
    .i_vm_synch  (i_vm_synch),
    .i_vm_raw    (i_vm_raw),
    .i_pixel     (i_pixel),
    .o_rd        (o_rd),
    .o_newline   (o_newline),
    .o_newframe  (o_newframe),
    .o_hsync     (o_hsync),
    .o_vsync     (o_vsync),
    .o_de        (o_de),
    .o_pixel     (o_pixel)
  );

  // Pattern source: registered count of requests within the current line.
  logic [3*BPC-1:0] src_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_cnt <= '0;
      i_pixel <= '0;
    end else if (o_newline) begin
      src_cnt <= '0;
    end else if (o_rd) begin
      i_pixel <= src_cnt;
      src_cnt <= src_cnt + 1'b1;
    end
  end

  typedef struct { int hw, hp, hs, hr, vh, vp, vs, vr; } mode_t;
  typedef struct { bit rd, nl, nf, hs, vs; int h; } st_t;
  typedef struct { int period, rd, hs, vs; } frame_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  frame_t frames[$];

  bit     m_run = 0;
  int     m_idx = 0;
  mode_t  m_mode;
  st_t    s1, s2;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mode_ok(input mode_t m);
    return m.hw > 0 && m.hw < m.hp && m.hp < m.hs && m.hs < m.hr &&
           m.vh > 0 && m.vh < m.vp && m.vp < m.vs && m.vs < m.vr;
  endfunction

  function automatic mode_t mode_in();
    mode_t m;
    m.hw = int'(i_hm_width);  m.hp = int'(i_hm_porch);
    m.hs = int'(i_hm_synch);  m.hr = int'(i_hm_raw);
    m.vh = int'(i_vm_height); m.vp = int'(i_vm_porch);
    m.vs = int'(i_vm_synch);  m.vr = int'(i_vm_raw);
    return m;
  endfunction

  // Model: the raster is a linear index within the frame; stage 1 shows the
  // index of one cycle ago, stage 2 the index of two cycles ago.
  initial begin
    int cyc = 0, last_nf = 0, rd_c = 0, hs_c = 0, vs_c = 0;
    bit have_last = 0;
    s1 = '{default: 0};
    s2 = '{default: 0};
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check("rst_rd", int'(o_rd), 0);
        check("rst_de", int'(o_de), 0);
        check("rst_hsync", int'(o_hsync), int'(!HP));
        check("rst_vsync", int'(o_vsync), int'(!VP));
        check("rst_pixel", int'(o_pixel), 0);
        m_run = 0; m_idx = 0; have_last = 0;
        s1 = '{default: 0};
        s2 = '{default: 0};
      end else begin
        st_t   n;
        mode_t cur;
        int    h, v;
        check("rd", int'(o_rd), int'(s1.rd));
        check("newline", int'(o_newline), int'(s1.nl));
        check("newframe", int'(o_newframe), int'(s1.nf));
        check("de", int'(o_de), int'(s2.rd));
        check("hsync", int'(o_hsync), s2.hs ? int'(HP) : int'(!HP));
        check("vsync", int'(o_vsync), s2.vs ? int'(VP) : int'(!VP));
        check("pixel", int'(o_pixel), s2.rd ? s2.h : 0);

        if (!m_run) have_last = 0;
        if (o_newframe) begin
          if (have_last) frames.push_back('{cyc - last_nf, rd_c, hs_c, vs_c});
          have_last = 1; last_nf = cyc;
          rd_c = 0; hs_c = 0; vs_c = 0;
        end
        rd_c += int'(o_rd);
        hs_c += int'(o_hsync == HP);
        vs_c += int'(o_vsync == VP);

        n   = '{default: 0};
        cur = mode_in();
        if (!m_run) begin
          if (i_en && mode_ok(cur)) begin
            m_mode = cur; m_run = 1; m_idx = 0;
            n.nl = 1; n.nf = 1;
          end
        end else begin
          h = m_idx % m_mode.hr;
          v = m_idx / m_mode.hr;
          n.rd = (h < m_mode.hw) && (v < m_mode.vh);
          n.hs = (h >= m_mode.hp) && (h < m_mode.hs);
          n.vs = (v >= m_mode.vp) && (v < m_mode.vs);
          n.h  = h;
          if (m_idx == m_mode.hr * m_mode.vr - 1) begin
            if (i_en && mode_ok(cur)) begin
              n.nl = 1; n.nf = 1; m_mode = cur;
            end else begin
              m_run = 0;
            end
            m_idx = 0;
          end else begin
            n.nl = (h == m_mode.hr - 1);
            m_idx++;
          end
        end
        s2 = s1;
        s1 = n;
      end
    end
  end

  task automatic wait_frames(input int target, input int budget, input string name);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if (frames.size() >= target) begin ok = 1; break; end
    end
    #1;
    check(name, int'(ok), 1);
  endtask

  task automatic check_frame(input int idx, input int per, input int rd, input int hs,
                             input int vs, input string tag);
    frame_t f;
    f = frames[idx];
    check({tag, "_period"}, f.period, per);
    check({tag, "_rd"}, f.rd, rd);
    check({tag, "_hs"}, f.hs, hs);
    check({tag, "_vs"}, f.vs, vs);
  endtask

  initial begin
    int base, c_rd, c_de, c_nl, c_nf, c_hs, c_vs, c_px;
    bit ok;
    rst_n = 0; i_en = 0;
    i_hm_width = 8; i_hm_porch = 10; i_hm_synch = 12; i_hm_raw = 16;
    i_vm_height = 4; i_vm_porch = 5; i_vm_synch = 6; i_vm_raw = 8;
    #2;
    check("init_rd", int'(o_rd), 0);
    check("init_newframe", int'(o_newframe), 0);
    check("init_hsync", int'(o_hsync), 1);
    check("init_vsync", int'(o_vsync), 1);
    check("init_pixel", int'(o_pixel), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1; i_en = 1;

    // Basic timing of the 16x8 test mode.
    wait_frames(2, 400, "t1_wait");
    check_frame(0, 128, 32, 16, 16, "t1_f0");
    check_frame(1, 128, 32, 16, 16, "t1_f1");

    // Raw change at vcount=2 applies only from the next frame.
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (m_run && m_idx == 2 * 16 + 3) begin ok = 1; break; end
    end
    #1;
    check("t2_wait_v2", int'(ok), 1);
    base = frames.size();
    i_hm_raw = 20;
    wait_frames(base + 2, 400, "t2_wait");
    check_frame(base, 128, 32, 16, 16, "t2_cur");
    check_frame(base + 1, 160, 32, 16, 20, "t2_next");

    // Invalid porch: IDLE at the next boundary, everything quiet.
    i_hm_porch = 7;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      if (!m_run) begin ok = 1; break; end
    end
    check("t3_wait_idle", int'(ok), 1);
    repeat (2) @(posedge clk);
    c_rd = 0; c_de = 0; c_nl = 0; c_nf = 0; c_hs = 0; c_vs = 0; c_px = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      c_rd += int'(o_rd); c_de += int'(o_de);
      c_nl += int'(o_newline); c_nf += int'(o_newframe);
      c_hs += int'(o_hsync == HP); c_vs += int'(o_vsync == VP);
      c_px += int'(o_pixel != '0);
    end
    check("t3_idle_rd", c_rd, 0);
    check("t3_idle_de", c_de, 0);
    check("t3_idle_strobes", c_nl + c_nf, 0);
    check("t3_idle_syncs", c_hs + c_vs, 0);
    check("t3_idle_pixel", c_px, 0);
    @(posedge clk);
    #1 i_hm_porch = 10; i_hm_raw = 16;

    // Disable, then re-enable: one entry strobe pair, then a normal frame.
    repeat (40) @(posedge clk);
    #1 i_en = 0;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      if (!m_run) begin ok = 1; break; end
    end
    check("t4_wait_idle", int'(ok), 1);
    repeat (3) @(posedge clk);
    #1 i_en = 1;
    base = frames.size();
    c_nl = 0; c_nf = 0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      c_nl += int'(o_newline); c_nf += int'(o_newframe);
    end
    check("t4_newline_cnt", c_nl, 1);
    check("t4_newframe_cnt", c_nf, 1);
    wait_frames(base + 1, 300, "t4_wait");
    check_frame(base, 128, 32, 16, 16, "t4_f");

    // Asynchronous reset mid-line at hcount=5, vcount=1.
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (m_run && m_idx == 21) begin ok = 1; break; end
    end
    #2;
    check("t5_wait", int'(ok), 1);
    check("t5_pre_rd", int'(o_rd), 1);
    check("t5_pre_de", int'(o_de), 1);
    check("t5_pre_pixel", int'(o_pixel), 3);
    rst_n = 0;
    #1;
    check("t5_rst_rd", int'(o_rd), 0);
    check("t5_rst_de", int'(o_de), 0);
    check("t5_rst_pixel", int'(o_pixel), 0);
    check("t5_rst_strobes", int'(o_newline) + int'(o_newframe), 0);
    check("t5_rst_hsync", int'(o_hsync), 1);
    check("t5_rst_vsync", int'(o_vsync), 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    base = frames.size();
    wait_frames(base + 1, 300, "t5_wait_restart");
    check_frame(base, 128, 32, 16, 16, "t5_f");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
